// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO.
// Radix-2: shift-add multiply, restoring divide; 33-cycle fixed latency.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] result,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        is_sgn_q, is_sgn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        div0_q, div0_d;

    logic        op_ok;
    logic        sgn_in;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_sh, div_tr;
    logic [63:0] div_nxt;
    logic [63:0] prod_neg;
    logic [31:0] quo_neg, rem_neg;
    logic        neg_q, neg_r;

    assign op_ok  = (ALUControl[4:2] == 3'b001);
    assign sgn_in = ~ALUControl[0];
    assign mag_a  = (sgn_in && A[31]) ? (32'd0 - A) : A;
    assign mag_b  = (sgn_in && B[31]) ? (32'd0 - B) : B;

    // opnd_q is the multiplicand (multiply) or divisor (divide)
    assign mul_sum = {1'b0, prod_q[63:32]}
                   + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_nxt = {mul_sum, prod_q[31:1]};

    assign div_sh  = prod_q[63:31];
    assign div_tr  = div_sh - {1'b0, opnd_q};
    assign div_nxt = div_tr[32] ? {div_sh[31:0], prod_q[30:0], 1'b0}
                                : {div_tr[31:0], prod_q[30:0], 1'b1};

    assign prod_neg = 64'd0 - prod_q;
    assign quo_neg  = 32'd0 - prod_q[31:0];
    assign rem_neg  = 32'd0 - prod_q[63:32];
    assign neg_q    = is_sgn_q & (a_q[31] ^ b_q[31]);
    assign neg_r    = is_sgn_q & a_q[31];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && op_ok) begin
                    state_d  = CALC;
                    cnt_d    = 5'd0;
                    is_div_d = ALUControl[1];
                    is_sgn_d = sgn_in;
                    a_d      = A;
                    b_d      = B;
                    opnd_d   = ALUControl[1] ? mag_b : mag_a;
                    prod_d   = {32'd0, ALUControl[1] ? mag_a : mag_b};
                end
            end
            CALC: begin
                prod_d = is_div_q ? div_nxt : mul_nxt;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
                end else if (b_q == 32'd0) begin
                    hi_d   = a_q;
                    lo_d   = 32'hFFFF_FFFF;
                    div0_d = 1'b1;
                end else begin
                    hi_d = neg_r ? rem_neg : prod_q[63:32];
                    lo_d = neg_q ? quo_neg : prod_q[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            opnd_q   <= 32'd0;
            prod_q   <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            is_sgn_q <= is_sgn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    always_comb begin
        result = 32'd0;
        if (ALUControl == 5'b10010) result = hi_q;
        else if (ALUControl == 5'b10011) result = lo_q;
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign div0  = div0_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign stall = busy & (op_ok | (ALUControl == 5'b10010)
                                 | (ALUControl == 5'b10011));

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Reference results come from plain signed/unsigned arithmetic.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  ALUControl;
    logic [31:0] A, B;
    logic        busy, done, div0, stall;
    logic [31:0] HI, LO, result;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] OP_MULT  = 5'b00100;
    localparam logic [4:0] OP_MULTU = 5'b00101;
    localparam logic [4:0] OP_DIV   = 5'b00110;
    localparam logic [4:0] OP_DIVU  = 5'b00111;
    localparam logic [4:0] OP_MFHI  = 5'b10010;
    localparam logic [4:0] OP_MFLO  = 5'b10011;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl),
        .A(A), .B(B), .busy(busy), .done(done), .div0(div0),
        .HI(HI), .LO(LO), .result(result), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [4:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        dz = 1'b0;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {hi, lo} = sp;
            end
            OP_MULTU: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                {hi, lo} = up;
            end
            OP_DIV: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    lo = sa / sb; hi = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Drives one start, then waits (bounded) for done; no checking here.
    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output int bcnt, output logic [31:0] hi0,
                         output logic [31:0] lo0);
        ALUControl = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ALUControl = 5'b00000;
        hi0 = HI; lo0 = LO;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; ALUControl = OP_MFLO; A = 0; B = 0;
        #2;
        checks++;
        if ({busy, done, div0, stall} !== 4'b0 || HI !== 0 || LO !== 0 || result !== 0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b div0=%b stall=%b HI=%h LO=%h res=%h, want all 0",
                     busy, done, div0, stall, HI, LO, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith;
        logic [4:0]  dop [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        logic [31:0] da  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] db  [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0,
                                 32'hFFFF_FFFF, 32'd0};
        logic [4:0]  dl  [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [4:0]  op;
        logic [31:0] a, b, eh, el, h0, l0;
        logic        ez;
        int          lat, bc;
        for (int i = 0; i < 46; i++) begin
            if (i < 6) begin
                op = dl[i]; a = da[i]; b = db[i];
            end else begin
                op = dop[$urandom_range(0, 3)];
                a = $urandom; b = $urandom;
                if ($urandom_range(0, 5) == 0) b = 32'd0;
                if ($urandom_range(0, 5) == 0) b = $urandom_range(1, 9);
                if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
                if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            end
            model(op, a, b, eh, el, ez);
            issue(op, a, b, lat, bc, h0, l0);
            checks++;
            if (lat !== 33 || bc !== 33) begin
                errors++;
                $display("FAIL latency op=%b a=%h b=%h: done at %0d busy %0d, want 33/33",
                         op, a, b, lat, bc);
            end
            checks++;
            if (HI !== eh || LO !== el || div0 !== ez) begin
                errors++;
                $display("FAIL result op=%b a=%h b=%h: HI=%h LO=%h div0=%b, want %h %h %b",
                         op, a, b, HI, LO, div0, eh, el, ez);
            end
            ALUControl = OP_MFHI; #1;
            checks++;
            if (result !== eh) begin
                errors++;
                $display("FAIL mfhi: result=%h, want %h", result, eh);
            end
            ALUControl = OP_MFLO; #1;
            checks++;
            if (result !== el || stall !== 1'b0) begin
                errors++;
                $display("FAIL mflo idle: result=%h stall=%b, want %h 0", result, stall, el);
            end
            ALUControl = 5'b00000;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || div0 !== 1'b0 || busy !== 1'b0 || result !== 0) begin
                errors++;
                $display("FAIL pulse: done=%b div0=%b busy=%b res=%h, want 0 0 0 0",
                         done, div0, busy, result);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] h0, l0;
        int          lat, bc;
        logic [31:0] er;
        issue(OP_DIVU, 32'd100, 32'd7, lat, bc, h0, l0);
        checks++;
        if (LO !== 32'd14 || HI !== 32'd2) begin
            errors++;
            $display("FAIL divu 100/7: HI=%h LO=%h, want 2 14", HI, LO);
        end
        ALUControl = OP_MULTU; A = 32'd3; B = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 33; c++) begin
            if (c == 5) begin
                start = 1'b1; ALUControl = OP_DIV; A = 32'd9; B = 32'd0;
            end else if (c == 8) begin
                start = 1'b0; ALUControl = 5'b00001;
            end else begin
                start = 1'b0; ALUControl = OP_MFLO;
            end
            #1;
            er = (c == 5 || c == 8) ? 32'd0 : 32'd14;
            checks++;
            if (busy !== 1'b1 || stall !== (c != 8) || result !== er || done !== 1'b0) begin
                errors++;
                $display("FAIL busy cyc %0d: busy=%b stall=%b res=%h done=%b, want 1 %b %h 0",
                         c, busy, stall, result, done, c != 8, er);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1 || LO !== 32'd12 || HI !== 32'd0 || div0 !== 1'b0) begin
            errors++;
            $display("FAIL ignore end: done=%b HI=%h LO=%h div0=%b, want 1 0 c 0",
                     done, HI, LO, div0);
        end
        ALUControl = 5'b00000;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore after: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_invalid_start;
        logic [4:0] bad [3] = '{OP_MFHI, 5'b01000, 5'b00011};
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; ALUControl = bad[i]; A = 32'd5; B = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
                errors++;
                $display("FAIL invalid %b: busy=%b stall=%b HI=%h LO=%h, want 0 0 0 c",
                         bad[i], busy, stall, HI, LO);
            end
        end
        ALUControl = 5'b00000;
    endtask

    task automatic test_back_to_back;
        logic [31:0] h0, l0;
        int          lat, bc;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat, bc, h0, l0);
        checks++;
        if (done !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL b2b first: done=%b HI=%h LO=%h, want 1 ffffffff fffffffa",
                     done, HI, LO);
        end
        issue(OP_DIVU, 32'd100, 32'd7, lat, bc, h0, l0);
        checks++;
        if (h0 !== 32'hFFFF_FFFF || l0 !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL b2b hold: HI=%h LO=%h, want ffffffff fffffffa", h0, l0);
        end
        checks++;
        if (lat !== 33 || bc !== 33 || HI !== 32'd2 || LO !== 32'd14) begin
            errors++;
            $display("FAIL b2b second: lat=%0d busy=%0d HI=%h LO=%h, want 33 33 2 e",
                     lat, bc, HI, LO);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        logic [31:0] h0, l0;
        int          lat, bc;
        issue(OP_MULTU, 32'd7, 32'd9, lat, bc, h0, l0);
        checks++;
        if (LO !== 32'd63 || HI !== 32'd0) begin
            errors++;
            $display("FAIL pre-abort: HI=%h LO=%h, want 0 3f", HI, LO);
        end
        ALUControl = OP_MULT; A = 32'h1234_5678; B = 32'h8765_4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ALUControl = OP_MFLO;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div0, stall} !== 4'b0 || HI !== 0 || LO !== 0 || result !== 0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b div0=%b stall=%b HI=%h LO=%h res=%h, want 0",
                     busy, done, div0, stall, HI, LO, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || LO !== 0) begin
            errors++;
            $display("FAIL post-abort: busy=%b done=%b LO=%h, want 0 0 0", busy, done, LO);
        end
        issue(OP_MULTU, 32'd5, 32'd6, lat, bc, h0, l0);
        checks++;
        if (lat !== 33 || bc !== 33 || LO !== 32'd30 || HI !== 32'd0) begin
            errors++;
            $display("FAIL after abort: lat=%0d busy=%0d HI=%h LO=%h, want 33 33 0 1e",
                     lat, bc, HI, LO);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_ignore();
        test_invalid_start();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
